// File: rtl/idecode.sv
// Instruction decode stage: register file with write-back bypass, BEQZ/JMP
// resolution back to fetch, load-use hazard stall and the decode/execute
// pipeline register.
//
// Handshake: fetch holds inst_i/inst_addr_i steady while stall_o=1 and
// redirects on branch_o=1. Execute signals hold_i=1 to freeze this stage.
// ex_valid_o=1 marks a real instruction in ex_*; ex_valid_o=0 is a bubble.
module idecode #(
    parameter int ADDR  = 16,
    parameter int WORD  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WORD-1:0]  inst_i,
    input  logic [ADDR-1:0]  inst_addr_i,
    input  logic             hold_i,
    input  logic             wb_we_i,
    input  logic [RADDR-1:0] wb_addr_i,
    input  logic [WORD-1:0]  wb_data_i,
    output logic             branch_o,
    output logic [ADDR-1:0]  branch_addr_o,
    output logic             stall_o,
    output logic             ex_valid_o,
    output logic [5:0]       ex_op_o,
    output logic [3:0]       ex_func_o,
    output logic [RADDR-1:0] ex_rd_o,
    output logic [WORD-1:0]  ex_a_o,
    output logic [WORD-1:0]  ex_b_o,
    output logic [WORD-1:0]  ex_imm_o,
    output logic [ADDR-1:0]  ex_addr_o
);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ALU  = 6'h01;
    localparam logic [5:0] OP_ALUI = 6'h02;
    localparam logic [5:0] OP_LD   = 6'h03;
    localparam logic [5:0] OP_ST   = 6'h04;
    localparam logic [5:0] OP_BEQZ = 6'h05;
    localparam logic [5:0] OP_JMP  = 6'h06;

    // Instruction fields; unknown opcodes collapse to NOP here.
    logic [5:0]       w_op_raw;
    logic [5:0]       w_op;
    logic [RADDR-1:0] w_rd;
    logic [RADDR-1:0] w_rs;
    logic [RADDR-1:0] w_rt;
    logic [15:0]      w_imm;
    logic [WORD-1:0]  w_imm_sx;

    assign w_op_raw = inst_i[31:26];
    assign w_op     = (w_op_raw > OP_JMP) ? OP_NOP : w_op_raw;
    assign w_rd     = inst_i[25:21];
    assign w_rs     = inst_i[20:16];
    assign w_imm    = inst_i[15:0];
    assign w_rt     = w_imm[15:11];
    assign w_imm_sx = {{(WORD-16){w_imm[15]}}, w_imm};

    // Per-opcode operand usage.
    logic w_use_rs, w_use_rt, w_use_rd, w_use_imm, w_use_func;
    assign w_use_rs   = (w_op >= OP_ALU)  && (w_op <= OP_BEQZ);
    assign w_use_rt   = (w_op == OP_ALU)  || (w_op == OP_ST);
    assign w_use_rd   = (w_op >= OP_ALU)  && (w_op <= OP_LD);
    assign w_use_imm  = (w_op >= OP_ALUI) && (w_op <= OP_JMP);
    assign w_use_func = (w_op == OP_ALU)  || (w_op == OP_ALUI);

    // Register file storage; r0 is never written and is masked on read.
    logic [WORD-1:0] r_rf [2**RADDR];

    // Write-back port keeps accepting writes during hold and reset.
    always_ff @(posedge clk) begin
        if (wb_we_i && (wb_addr_i != '0)) r_rf[wb_addr_i] <= wb_data_i;
    end

    logic [WORD-1:0] w_rs_val;
    logic [WORD-1:0] w_rt_val;
    assign w_rs_val = (w_rs == '0) ? '0 :
                      (wb_we_i && (wb_addr_i == w_rs)) ? wb_data_i : r_rf[w_rs];
    assign w_rt_val = (w_rt == '0) ? '0 :
                      (wb_we_i && (wb_addr_i == w_rt)) ? wb_data_i : r_rf[w_rt];

    // Hazard, branch and stall resolution.
    logic r_annul;
    logic w_hazard;
    logic w_taken;
    logic w_bubble;

    assign w_hazard = ex_valid_o && (ex_op_o == OP_LD) && (ex_rd_o != '0) &&
                      ((ex_rd_o == w_rs) || (w_use_rt && (ex_rd_o == w_rt)));
    assign w_taken  = ((w_op == OP_BEQZ) && (w_rs_val == '0)) || (w_op == OP_JMP);
    assign w_bubble = r_annul || w_hazard;

    assign branch_o      = rst && !hold_i && !r_annul && !w_hazard && w_taken;
    assign stall_o       = rst && (hold_i || (!r_annul && w_hazard));
    assign branch_addr_o = (w_op == OP_BEQZ) ? (inst_addr_i + w_imm[ADDR-1:0])
                                             : w_imm[ADDR-1:0];

    // Decode/execute pipeline register and annul flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_annul    <= 1'b0;
            ex_valid_o <= 1'b0;
            ex_op_o    <= '0;
            ex_func_o  <= '0;
            ex_rd_o    <= '0;
            ex_a_o     <= '0;
            ex_b_o     <= '0;
            ex_imm_o   <= '0;
            ex_addr_o  <= '0;
        end else if (!hold_i) begin
            r_annul <= branch_o;
            if (w_bubble) begin
                ex_valid_o <= 1'b0;
                ex_op_o    <= '0;
                ex_func_o  <= '0;
                ex_rd_o    <= '0;
                ex_a_o     <= '0;
                ex_b_o     <= '0;
                ex_imm_o   <= '0;
                ex_addr_o  <= '0;
            end else begin
                ex_valid_o <= 1'b1;
                ex_op_o    <= w_op;
                ex_func_o  <= w_use_func ? w_imm[3:0] : 4'h0;
                ex_rd_o    <= w_use_rd   ? w_rd       : '0;
                ex_a_o     <= w_use_rs   ? w_rs_val   : '0;
                ex_b_o     <= w_use_rt   ? w_rt_val   : '0;
                ex_imm_o   <= w_use_imm  ? w_imm_sx   : '0;
                ex_addr_o  <= inst_addr_i;
            end
        end
    end

endmodule

// File: tb/tb_idecode.sv
// Bench for idecode: directed instruction sequence, a cycle-level reference
// model checked on every falling edge, and literal spot checks.
module tb_idecode;

    logic        clk;
    logic        rst;
    logic [31:0] inst_i;
    logic [15:0] inst_addr_i;
    logic        hold_i;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        branch_o;
    logic [15:0] branch_addr_o;
    logic        stall_o;
    logic        ex_valid_o;
    logic [5:0]  ex_op_o;
    logic [3:0]  ex_func_o;
    logic [4:0]  ex_rd_o;
    logic [31:0] ex_a_o;
    logic [31:0] ex_b_o;
    logic [31:0] ex_imm_o;
    logic [15:0] ex_addr_o;

    int total = 0;
    int bad   = 0;

    idecode dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .hold_i(hold_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i),
        .wb_data_i(wb_data_i), .branch_o(branch_o), .branch_addr_o(branch_addr_o),
        .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_op_o(ex_op_o),
        .ex_func_o(ex_func_o), .ex_rd_o(ex_rd_o), .ex_a_o(ex_a_o),
        .ex_b_o(ex_b_o), .ex_imm_o(ex_imm_o), .ex_addr_o(ex_addr_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // reference model state: what ex_* must hold right now
    logic        m_valid, m_annul;
    logic [5:0]  m_op;
    logic [3:0]  m_func;
    logic [4:0]  m_rd;
    logic [31:0] m_a, m_b, m_imm;
    logic [15:0] m_addr;
    logic [31:0] m_rf [32];

    initial begin
        m_valid = 0; m_annul = 0; m_op = 0; m_func = 0; m_rd = 0;
        m_a = 0; m_b = 0; m_imm = 0; m_addr = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 0) return 0;
        if (wb_we_i && wb_addr_i == idx) return wb_data_i;
        return m_rf[idx];
    endfunction

    // compare process: check DUT against model, then advance model one cycle
    always @(negedge clk) begin
        logic [5:0]  op;
        logic [4:0]  rs, rd, rt;
        logic [15:0] imm;
        logic [31:0] rsv, rtv, sx;
        logic        hz, taken, e_br, e_st;
        logic [15:0] tgt;
        if (!rst) begin
            m_valid = 0; m_annul = 0; m_op = 0; m_func = 0; m_rd = 0;
            m_a = 0; m_b = 0; m_imm = 0; m_addr = 0;
        end
        chk("ex_valid", {31'b0, ex_valid_o}, {31'b0, m_valid});
        chk("ex_op", {26'b0, ex_op_o}, {26'b0, m_op});
        chk("ex_func", {28'b0, ex_func_o}, {28'b0, m_func});
        chk("ex_rd", {27'b0, ex_rd_o}, {27'b0, m_rd});
        chk("ex_a", ex_a_o, m_a);
        chk("ex_b", ex_b_o, m_b);
        chk("ex_imm", ex_imm_o, m_imm);
        chk("ex_addr", {16'b0, ex_addr_o}, {16'b0, m_addr});

        op  = (inst_i[31:26] <= 6'h06) ? inst_i[31:26] : 6'h00;
        rd  = inst_i[25:21];
        rs  = inst_i[20:16];
        imm = inst_i[15:0];
        rt  = imm[15:11];
        rsv = m_read(rs);
        rtv = m_read(rt);
        sx  = {{16{imm[15]}}, imm};
        hz  = m_valid && m_op == 6'h03 && m_rd != 0 &&
              (m_rd == rs || ((op == 6'h01 || op == 6'h04) && m_rd == rt));
        taken = (op == 6'h05 && rsv == 0) || op == 6'h06;
        tgt   = (op == 6'h05) ? 16'(inst_addr_i + imm) : imm;

        if (!rst)         begin e_br = 0;     e_st = 0; end
        else if (hold_i)  begin e_br = 0;     e_st = 1; end
        else if (m_annul) begin e_br = 0;     e_st = 0; end
        else if (hz)      begin e_br = 0;     e_st = 1; end
        else              begin e_br = taken; e_st = 0; end
        chk("branch", {31'b0, branch_o}, {31'b0, e_br});
        chk("stall", {31'b0, stall_o}, {31'b0, e_st});
        if (e_br) chk("branch_addr", {16'b0, branch_addr_o}, {16'b0, tgt});

        if (rst && !hold_i) begin
            if (m_annul || hz) begin
                m_valid = 0; m_op = 0; m_func = 0; m_rd = 0;
                m_a = 0; m_b = 0; m_imm = 0; m_addr = 0;
            end else begin
                m_valid = 1; m_op = op; m_addr = inst_addr_i;
                m_func = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0;
                case (op)
                    6'h01: begin m_func = imm[3:0]; m_rd = rd; m_a = rsv; m_b = rtv; end
                    6'h02: begin m_func = imm[3:0]; m_rd = rd; m_a = rsv; m_imm = sx; end
                    6'h03: begin m_rd = rd; m_a = rsv; m_imm = sx; end
                    6'h04: begin m_a = rsv; m_b = rtv; m_imm = sx; end
                    6'h05: begin m_a = rsv; m_imm = sx; end
                    6'h06: begin m_imm = sx; end
                    default: ;
                endcase
            end
            m_annul = m_annul ? 1'b0 : e_br;
        end
        if (wb_we_i && wb_addr_i != 0) m_rf[wb_addr_i] = wb_data_i;
    end

    // driver tasks
    task automatic put(input logic [31:0] inst, input logic [15:0] addr, input logic h,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        inst_i = inst; inst_addr_i = addr; hold_i = h;
        wb_we_i = we; wb_addr_i = wa; wb_data_i = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // directed stimulus with literal expectations
    initial begin
        rst = 0;
        put(32'h0, 16'h0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("rst_valid", {31'b0, ex_valid_o}, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_branch", {31'b0, branch_o}, 32'd0);
        rst = 1;

        for (int i = 1; i < 32; i++) begin
            put(32'h0, 16'(i), 0, 1, 5'(i), (32'(i) * 32'h01010101) ^ 32'hA5A50000);
            tick();
        end
        put(32'h0, 16'h0, 0, 1, 5'd1, 32'h5);
        tick();

        // ALUI r2 = r1 + 0xFFFF
        put({6'h02, 5'd2, 5'd1, 16'hFFFF}, 16'h0001, 0, 0, 0, 0);
        tick();
        chk("alui_valid", {31'b0, ex_valid_o}, 32'd1);
        chk("alui_a", ex_a_o, 32'h5);
        chk("alui_imm", ex_imm_o, 32'hFFFFFFFF);
        chk("alui_rd", {27'b0, ex_rd_o}, 32'd2);

        // ALU r4 = r3 op r3 while r3 is being written back
        put({6'h01, 5'd4, 5'd3, 5'd3, 11'h0}, 16'h0002, 0, 1, 5'd3, 32'h12345678);
        tick();
        chk("byp_a", ex_a_o, 32'h12345678);
        chk("byp_b", ex_b_o, 32'h12345678);

        // load-use: LD r5 then ALU reading r5
        put({6'h03, 5'd5, 5'd1, 16'h0004}, 16'h0010, 0, 0, 0, 0);
        tick();
        chk("ld_op", {26'b0, ex_op_o}, 32'd3);
        put({6'h01, 5'd6, 5'd5, 16'h0000}, 16'h0011, 0, 0, 0, 0);
        chk("lu_stall", {31'b0, stall_o}, 32'd1);
        tick();
        chk("lu_bubble", {31'b0, ex_valid_o}, 32'd0);
        put({6'h01, 5'd6, 5'd5, 16'h0000}, 16'h0011, 0, 0, 0, 0);
        chk("lu_nostall", {31'b0, stall_o}, 32'd0);
        tick();
        chk("lu_valid", {31'b0, ex_valid_o}, 32'd1);
        chk("lu_addr", {16'b0, ex_addr_o}, 32'h0011);

        // BEQZ r0 taken, wrong-path JMP annulled
        put({6'h05, 5'd0, 5'd0, 16'h0008}, 16'h0020, 0, 0, 0, 0);
        chk("beqz_br", {31'b0, branch_o}, 32'd1);
        chk("beqz_tgt", {16'b0, branch_addr_o}, 32'h0028);
        tick();
        put({6'h06, 5'd0, 5'd0, 16'h1234}, 16'h0021, 0, 0, 0, 0);
        chk("annul_br", {31'b0, branch_o}, 32'd0);
        chk("annul_stall", {31'b0, stall_o}, 32'd0);
        tick();
        chk("annul_valid", {31'b0, ex_valid_o}, 32'd0);

        // BEQZ r1 (=5) not taken
        put({6'h05, 5'd0, 5'd1, 16'h0008}, 16'h0030, 0, 0, 0, 0);
        chk("beqz_nt", {31'b0, branch_o}, 32'd0);
        tick();
        chk("beqz_nt_valid", {31'b0, ex_valid_o}, 32'd1);
        chk("beqz_nt_op", {26'b0, ex_op_o}, 32'd5);

        // JMP at 0xFFFF
        put({6'h06, 5'd0, 5'd0, 16'h0003}, 16'hFFFF, 0, 0, 0, 0);
        chk("jmp_br", {31'b0, branch_o}, 32'd1);
        chk("jmp_tgt", {16'b0, branch_addr_o}, 32'h0003);
        tick();
        put(32'h0, 16'h0000, 0, 0, 0, 0);
        tick();

        // unknown opcode decodes as NOP
        put({6'h3F, 5'd7, 5'd1, 16'h8001}, 16'h0040, 0, 0, 0, 0);
        tick();
        chk("unk_op", {26'b0, ex_op_o}, 32'd0);
        chk("unk_valid", {31'b0, ex_valid_o}, 32'd1);

        // BEQZ target wrap-around
        put({6'h05, 5'd0, 5'd0, 16'h0002}, 16'hFFFF, 0, 0, 0, 0);
        chk("wrap_tgt", {16'b0, branch_addr_o}, 32'h0001);
        tick();

        // hold with annul pending, then reset mid-hold
        for (int i = 0; i < 3; i++) begin
            put({6'h06, 5'd0, 5'd0, 16'h0077}, 16'h0000, 1, 0, 0, 0);
            chk("hold_stall", {31'b0, stall_o}, 32'd1);
            chk("hold_br", {31'b0, branch_o}, 32'd0);
            tick();
            chk("hold_op", {26'b0, ex_op_o}, 32'd5);
            chk("hold_addr", {16'b0, ex_addr_o}, 32'hFFFF);
        end
        rst = 0;
        #1;
        chk("mrst_valid", {31'b0, ex_valid_o}, 32'd0);
        chk("mrst_addr", {16'b0, ex_addr_o}, 32'd0);
        chk("mrst_stall", {31'b0, stall_o}, 32'd0);
        tick();
        rst = 1;
        put(32'h0, 16'h0050, 0, 0, 0, 0);
        tick();
        chk("post_valid", {31'b0, ex_valid_o}, 32'd1);
        chk("post_op", {26'b0, ex_op_o}, 32'd0);

        repeat (2) tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
